// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// the NOP filler word and the default reset fetch address.
package fetch_stage_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage
// (master) and the instruction memory (slave).
interface fetch_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_stage_fifo.sv
// Small {pc, instr} buffer between the memory response and the IF/ID
// register; flush has priority over push and pop.
module fetch_fifo
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [31:0]                i_push_pc,
    input  logic [31:0]                i_push_instr,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic [31:0]                o_head_pc,
    output logic [31:0]                o_head_instr
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [31:0]      r_pc    [DEPTH];
    logic [31:0]      r_instr [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_do_push = i_push && (r_count != FULL);
    assign w_do_pop  = i_pop && (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= NOP_INSTR;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_pc[r_wr_ptr]    <= i_push_pc;
                r_instr[r_wr_ptr] <= i_push_instr;
                r_wr_ptr          <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count      = r_count;
    assign o_full       = (r_count == FULL);
    assign o_head_pc    = r_pc[r_rd_ptr];
    assign o_head_instr = r_instr[r_rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding memory request, 2-entry
// prefetch buffer, redirect with discard of a stale in-flight response.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_RUN   | normal fetch: request while buffer has room, push acks
// ST_DRAIN | hold the abandoned request until its ack, drop the data
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          PC_EN_IF,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    fetch_stage_if.master imem,
    output logic          inst_valid,
    output logic [31:0]   inst_IF,
    output logic [31:0]   PC_IF
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      w_fetch_pc_nxt;
    logic [31:0]      r_drain_addr;
    logic [31:0]      w_drain_addr_nxt;
    logic             r_started;
    logic             w_req;
    logic [31:0]      w_addr;
    logic             w_push;
    logic             w_pop;
    logic             w_flush;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic [31:0]      w_head_pc;
    logic [31:0]      w_head_instr;
    logic [31:0]      w_redirect_target;

    assign w_redirect_target = word_align(redirect_pc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_fetch_pc   <= RESET_PC;
            r_drain_addr <= '0;
            r_started    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_drain_addr <= w_drain_addr_nxt;
            r_started    <= 1'b1;
        end
    end

    // r_started keeps imem_req low until the first edge after reset release,
    // so an ack landing in that window finds no request and is ignored.
    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_drain_addr_nxt = r_drain_addr;
        w_req            = 1'b0;
        w_addr           = r_fetch_pc;
        w_push           = 1'b0;
        w_flush          = 1'b0;
        w_pop            = inst_valid && PC_EN_IF && !redirect_valid;

        case (r_state)
            ST_RUN: begin
                w_req  = r_started && !w_full;
                w_addr = r_fetch_pc;
                if (redirect_valid) begin
                    w_flush        = 1'b1;
                    w_fetch_pc_nxt = w_redirect_target;
                    if (w_req && !imem.imem_ack) begin
                        w_state_nxt      = ST_DRAIN;
                        w_drain_addr_nxt = r_fetch_pc;
                    end
                end else if (w_req && imem.imem_ack) begin
                    w_push         = 1'b1;
                    w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                end
            end
            ST_DRAIN: begin
                w_req  = 1'b1;
                w_addr = r_drain_addr;
                if (imem.imem_ack) begin
                    w_state_nxt = ST_RUN;
                end
                if (redirect_valid) begin
                    w_flush        = 1'b1;
                    w_fetch_pc_nxt = w_redirect_target;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_flush      (w_flush),
        .i_push_pc    (r_fetch_pc),
        .i_push_instr (imem.imem_rdata),
        .o_count      (w_count),
        .o_full       (w_full),
        .o_head_pc    (w_head_pc),
        .o_head_instr (w_head_instr)
    );

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = w_addr;

    assign inst_valid = (w_count != '0);
    assign inst_IF    = inst_valid ? w_head_instr : NOP_INSTR;
    assign PC_IF      = inst_valid ? w_head_pc : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory acks are driven explicitly per cycle
// and every observation is {inst_valid, PC_IF, inst_IF, imem_req, imem_addr}.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        PC_EN_IF;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_IF;
    logic [31:0] PC_IF;

    int total;
    int bad;

    logic [97:0] obs;
    logic [97:0] exp;

    fetch_stage_if u_imem ();

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .PC_EN_IF       (PC_EN_IF),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (u_imem),
        .inst_valid     (inst_valid),
        .inst_IF        (inst_IF),
        .PC_IF          (PC_IF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: each word is tagged by its own address.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [97:0] vec(input logic v, input logic [31:0] pc,
                                        input logic [31:0] ins, input logic req,
                                        input logic [31:0] addr);
        return {v, pc, ins, req, addr};
    endfunction

    function automatic logic [97:0] snap();
        return {inst_valid, PC_IF, inst_IF, u_imem.imem_req, u_imem.imem_addr};
    endfunction

    task automatic drive(input logic ack, input logic en, input logic redir,
                         input logic [31:0] rpc);
        u_imem.imem_ack   = ack;
        u_imem.imem_rdata = ack ? instr_of(u_imem.imem_addr) : 32'hDEAD_BEEF;
        PC_EN_IF          = en;
        redirect_valid    = redir;
        redirect_pc       = rpc;
        @(posedge clk);
        #1;
        u_imem.imem_ack = 1'b0;
        redirect_valid  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n             = 1'b0;
        PC_EN_IF          = 1'b1;
        redirect_valid    = 1'b0;
        redirect_pc       = '0;
        u_imem.imem_ack   = 1'b0;
        u_imem.imem_rdata = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n             = 1'b0;
        PC_EN_IF          = 1'b1;
        redirect_valid    = 1'b0;
        redirect_pc       = '0;
        u_imem.imem_ack   = 1'b0;
        u_imem.imem_rdata = '0;
        @(posedge clk);
        #1;
        obs = snap(); exp = vec(1'b0, 32'h0, NOP, 1'b0, 32'h0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL reset_hold got=%h want=%h", obs, exp); end
        rst_n = 1'b1;
        #2;
        obs = snap();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL reset_release got=%h want=%h", obs, exp); end
        @(posedge clk);
        #1;
        obs = snap(); exp = vec(1'b0, 32'h0, NOP, 1'b1, 32'h0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL first_req got=%h want=%h", obs, exp); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            obs = snap();
            exp = vec(1'b1, 32'(4 * i), instr_of(32'(4 * i)), 1'b1, 32'(4 * i + 4));
            total++;
            if (obs !== exp) begin bad++; $display("FAIL stream_%0d got=%h want=%h", i, obs, exp); end
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        obs = snap(); exp = vec(1'b0, 32'h0, NOP, 1'b1, 32'hC);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL stream_empty got=%h want=%h", obs, exp); end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        obs = snap(); exp = vec(1'b1, 32'h0, instr_of(32'h0), 1'b1, 32'h4);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL stall_1 got=%h want=%h", obs, exp); end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        obs = snap(); exp = vec(1'b1, 32'h0, instr_of(32'h0), 1'b0, 32'h8);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL stall_full got=%h want=%h", obs, exp); end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        obs = snap();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL stall_hold got=%h want=%h", obs, exp); end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        obs = snap(); exp = vec(1'b1, 32'h4, instr_of(32'h4), 1'b1, 32'h8);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL resume_4 got=%h want=%h", obs, exp); end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        obs = snap(); exp = vec(1'b1, 32'h8, instr_of(32'h8), 1'b1, 32'hC);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL resume_8 got=%h want=%h", obs, exp); end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        obs = snap(); exp = vec(1'b0, 32'h0, NOP, 1'b1, 32'hC);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL resume_empty got=%h want=%h", obs, exp); end
    endtask

    task automatic test_redirect_idle();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        obs = snap(); exp = vec(1'b1, 32'h0, instr_of(32'h0), 1'b0, 32'h8);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL idle_full got=%h want=%h", obs, exp); end
        drive(1'b0, 1'b1, 1'b1, 32'h100);
        obs = snap(); exp = vec(1'b0, 32'h0, NOP, 1'b1, 32'h100);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL idle_redirect got=%h want=%h", obs, exp); end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        obs = snap(); exp = vec(1'b1, 32'h100, instr_of(32'h100), 1'b1, 32'h104);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL idle_target got=%h want=%h", obs, exp); end
    endtask

    task automatic test_redirect_drain();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        obs = snap(); exp = vec(1'b1, 32'h4, instr_of(32'h4), 1'b1, 32'h8);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL drain_pre got=%h want=%h", obs, exp); end
        drive(1'b0, 1'b1, 1'b1, 32'h200);
        obs = snap(); exp = vec(1'b0, 32'h0, NOP, 1'b1, 32'h8);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL drain_enter got=%h want=%h", obs, exp); end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        obs = snap();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL drain_wait got=%h want=%h", obs, exp); end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        obs = snap(); exp = vec(1'b0, 32'h0, NOP, 1'b1, 32'h200);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL drain_drop got=%h want=%h", obs, exp); end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        obs = snap(); exp = vec(1'b1, 32'h200, instr_of(32'h200), 1'b1, 32'h204);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL drain_target got=%h want=%h", obs, exp); end
    endtask

    task automatic test_drain_redirect();
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 32'h40);
        obs = snap(); exp = vec(1'b0, 32'h0, NOP, 1'b1, 32'h0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL dr2_enter got=%h want=%h", obs, exp); end
        drive(1'b0, 1'b1, 1'b1, 32'h300);
        obs = snap();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL dr2_stay got=%h want=%h", obs, exp); end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        obs = snap(); exp = vec(1'b0, 32'h0, NOP, 1'b1, 32'h300);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL dr2_exit got=%h want=%h", obs, exp); end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        obs = snap(); exp = vec(1'b1, 32'h300, instr_of(32'h300), 1'b1, 32'h304);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL dr2_target got=%h want=%h", obs, exp); end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        obs = snap(); exp = vec(1'b1, 32'h8, instr_of(32'h8), 1'b1, 32'hC);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL rack_pre got=%h want=%h", obs, exp); end
        drive(1'b1, 1'b1, 1'b1, 32'h203);
        obs = snap(); exp = vec(1'b0, 32'h0, NOP, 1'b1, 32'h200);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL rack_redirect got=%h want=%h", obs, exp); end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        obs = snap(); exp = vec(1'b1, 32'h200, instr_of(32'h200), 1'b1, 32'h204);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL rack_target got=%h want=%h", obs, exp); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        obs = snap(); exp = vec(1'b1, 32'h0, instr_of(32'h0), 1'b1, 32'h4);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL rmid_pre got=%h want=%h", obs, exp); end
        #2;
        rst_n = 1'b0;
        #1;
        obs = snap(); exp = vec(1'b0, 32'h0, NOP, 1'b0, 32'h0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL rmid_async got=%h want=%h", obs, exp); end
        @(posedge clk);
        #1;
        rst_n             = 1'b1;
        PC_EN_IF          = 1'b1;
        u_imem.imem_ack   = 1'b1;
        u_imem.imem_rdata = instr_of(32'h4);
        @(posedge clk);
        #1;
        u_imem.imem_ack = 1'b0;
        obs = snap(); exp = vec(1'b0, 32'h0, NOP, 1'b1, 32'h0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL rmid_late_ack got=%h want=%h", obs, exp); end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        obs = snap(); exp = vec(1'b1, 32'h0, instr_of(32'h0), 1'b1, 32'h4);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL rmid_restart got=%h want=%h", obs, exp); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_idle();
        test_redirect_drain();
        test_drain_redirect();
        test_redirect_ack();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, is the fetched-instruction buffer depth; only 2 is required.
REQ-003 clk  in  1  is the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  is the asynchronous, active-low reset.
REQ-005 PC_EN_IF  in  1  is the hazard-unit enable; 0 means hold the presented instruction (stall).
REQ-006 redirect_valid  in  1  is the taken-branch/flush request from ID.
REQ-007 redirect_pc  in  32  is the redirect target; bits [1:0] are ignored and treated as 0.
REQ-008 imem_req  out  1  is the instruction-memory request.
REQ-009 imem_addr  out  32  is the request word address.
REQ-010 imem_ack  in  1  is the memory response strobe; it may arrive 1..N cycles after request.
REQ-011 imem_rdata  in  32  is the instruction word, valid when imem_ack=1.
REQ-012 inst_valid  out  1  is 1 when inst_IF/PC_IF hold a valid fetched instruction.
REQ-013 inst_IF  out  32  is the instruction to the IF/ID register.
REQ-014 PC_IF  out  32  is the address of inst_IF.

Function
REQ-015 The FSM SHALL have two states: RUN (normal fetch) and DRAIN (discard one stale response).
REQ-016 At most one memory request SHALL be outstanding at any time.
REQ-017 Handshake: once imem_req=1, imem_req and imem_addr SHALL hold stable until the cycle imem_ack=1.
REQ-018 In RUN, imem_req SHALL be 1 iff FIFO count < FIFO_DEPTH, and imem_addr SHALL equal fetch_pc.
REQ-019 In RUN on imem_ack=1 without redirect, {fetch_pc, imem_rdata} SHALL be pushed and fetch_pc SHALL advance by 4 (mod 2^32 wrap).
REQ-020 The FIFO head SHALL drive inst_IF/PC_IF; inst_valid SHALL equal (count != 0).
REQ-021 When inst_valid=1 and PC_EN_IF=1, the head SHALL pop at the clock edge; with PC_EN_IF=0, the outputs SHALL hold unchanged.
REQ-022 Push and pop in the same cycle SHALL both take effect and leave count unchanged.
REQ-023 When inst_valid=0, inst_IF SHALL be 32'h0000_0013 (NOP) and PC_IF SHALL be 0.
REQ-024 On redirect_valid=1, several actions SHALL occur at the same edge:
- the FIFO empties;
- fetch_pc loads {redirect_pc[31:2], 2'b00};
- any same-cycle ack data is discarded;
- redirect overrides pop, push and PC_EN_IF.
REQ-025 If a request is outstanding and unacked in the redirect cycle, the FSM SHALL enter DRAIN.
- drain_addr latches the old imem_addr.
- imem_req stays 1 with imem_addr=drain_addr until ack.
- That ack's data is dropped, and the FSM returns to RUN.
REQ-026 A further redirect during DRAIN SHALL update fetch_pc only and keep DRAIN.
REQ-027 Latency, no stall: ack at cycle a SHALL give inst_valid=1 at a+1.
REQ-028 Latency, after redirect: imem_req with the target address SHALL assert at t+1 if no request is outstanding.

Reset
REQ-029 While rst_n=0, the following SHALL hold immediately, independent of clk:
- state=RUN, FIFO empty, fetch_pc=RESET_PC, drain_addr=0;
- inst_valid=0, inst_IF=NOP, PC_IF=0;
- imem_req=0.
REQ-030 After rst_n deasserts, the first rising edge SHALL assert imem_req with imem_addr=RESET_PC.
REQ-031 Reset mid-handshake SHALL abandon the outstanding request; an ack arriving after reset release without a pending request SHALL be ignored.

Structure
REQ-032 The shared core package SHALL hold the RUN/DRAIN state encoding, the NOP constant 32'h0000_0013 and the default RESET_PC.
REQ-033 The 2-entry {pc, instr} buffer SHALL be a sub-module named fetch_fifo with push, pop, flush, count, head outputs and async active-low reset.

Verification
REQ-034 Reset release, ack latency 1, PC_EN_IF=1: PCs 0x0,0x4,0x8 SHALL appear on consecutive cycles with inst_valid=1.
REQ-035 PC_EN_IF=0 for 3 cycles with ack every cycle:
- the FIFO fills to 2 and imem_req drops;
- inst_IF/PC_IF hold PC 0x0;
- on resume, PCs 0x0, 0x4 and 0x8 follow in order.
REQ-036 Redirect to 0x100 with no request outstanding: the FIFO is emptied, imem_addr=0x100 at next cycle, and PC_IF=0x100 appears one cycle after its ack.
REQ-037 Redirect to 0x200 while request 0x8 is pending with ack latency 3:
- DRAIN holds imem_addr=0x8 until ack;
- the 0x8 data never reaches inst_IF;
- the next request is 0x200.
REQ-038 Redirect coincident with ack of 0xC: the 0xC data is dropped, with no DRAIN entry; redirect_pc=0x203 yields fetch of 0x200.
REQ-039 rst_n pulsed low mid-wait:
- outputs return to their reset values asynchronously;
- a late ack is ignored;
- fetch restarts at RESET_PC.
